// File: rtl/axi4lite_simple_master_if.sv
// AXI4-Lite bus bundle between a single master and a single slave.
// WSTRB width follows the data width (one strobe bit per byte).
interface axi4lite_simple_master_if #(
  parameter int C_M_AXI_ADDR_WIDTH = 14,
  parameter int C_M_AXI_DATA_WIDTH = 32
);

  logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR;
  logic                            M_AXI_AWVALID;
  logic                            M_AXI_AWREADY;

  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA;
  logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB;
  logic                            M_AXI_WVALID;
  logic                            M_AXI_WREADY;

  logic [1:0]                      M_AXI_BRESP;
  logic                            M_AXI_BVALID;
  logic                            M_AXI_BREADY;

  logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR;
  logic                            M_AXI_ARVALID;
  logic                            M_AXI_ARREADY;

  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA;
  logic [1:0]                      M_AXI_RRESP;
  logic                            M_AXI_RVALID;
  logic                            M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    output M_AXI_RREADY
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    input  M_AXI_RREADY
  );

endinterface

// File: rtl/axi4lite_simple_master.sv
// Simple-bus to AXI4-Lite initiator bridge: one outstanding single-beat
// transaction, registered outputs, completion status returned with done.
module axi4lite_simple_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 14,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESETN,
  input  logic                          wr,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] wrAddr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] wrData,
  input  logic                          rd,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] rdAddr,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [C_M_AXI_DATA_WIDTH-1:0] rdData,
  axi4lite_simple_master_if.master      m_axi
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int SW = C_M_AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4
  } state_t;

  state_t        state, state_nxt;

  logic          awvalid_r, awvalid_nxt;
  logic          wvalid_r,  wvalid_nxt;
  logic          bready_r,  bready_nxt;
  logic          arvalid_r, arvalid_nxt;
  logic          rready_r,  rready_nxt;
  logic          busy_r,    busy_nxt;
  logic          done_r,    done_nxt;
  logic          err_r,     err_nxt;
  logic [AW-1:0] awaddr_r,  awaddr_nxt;
  logic [DW-1:0] wdata_r,   wdata_nxt;
  logic [AW-1:0] araddr_r,  araddr_nxt;
  logic [DW-1:0] rd_data_r, rd_data_nxt;

  // A VALID is still owed to the slave when it was high and no READY came back.
  logic aw_hold, w_hold;
  logic b_fire, r_fire;

  assign aw_hold = awvalid_r & ~m_axi.M_AXI_AWREADY;
  assign w_hold  = wvalid_r  & ~m_axi.M_AXI_WREADY;
  assign b_fire  = (state == WR_B) & m_axi.M_AXI_BVALID;
  assign r_fire  = (state == RD_R) & m_axi.M_AXI_RVALID;

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state     <= IDLE;
      awvalid_r <= 1'b0;
      wvalid_r  <= 1'b0;
      bready_r  <= 1'b0;
      arvalid_r <= 1'b0;
      rready_r  <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      awaddr_r  <= '0;
      wdata_r   <= '0;
      araddr_r  <= '0;
      rd_data_r <= '0;
    end else begin
      state     <= state_nxt;
      awvalid_r <= awvalid_nxt;
      wvalid_r  <= wvalid_nxt;
      bready_r  <= bready_nxt;
      arvalid_r <= arvalid_nxt;
      rready_r  <= rready_nxt;
      busy_r    <= busy_nxt;
      done_r    <= done_nxt;
      err_r     <= err_nxt;
      awaddr_r  <= awaddr_nxt;
      wdata_r   <= wdata_nxt;
      araddr_r  <= araddr_nxt;
      rd_data_r <= rd_data_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (wr)      state_nxt = WR_AW_W;
        else if (rd) state_nxt = RD_AR;
      end
      // AW and W complete independently; leave only when neither is still owed.
      WR_AW_W: if (!aw_hold && !w_hold) state_nxt = WR_B;
      WR_B:    if (m_axi.M_AXI_BVALID)  state_nxt = IDLE;
      RD_AR:   if (m_axi.M_AXI_ARREADY) state_nxt = RD_R;
      RD_R:    if (m_axi.M_AXI_RVALID)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    awvalid_nxt = aw_hold;
    wvalid_nxt  = w_hold;
    awaddr_nxt  = awaddr_r;
    wdata_nxt   = wdata_r;
    araddr_nxt  = araddr_r;
    rd_data_nxt = rd_data_r;
    err_nxt     = err_r;

    if (state == IDLE) begin
      if (wr) begin
        awvalid_nxt = 1'b1;
        wvalid_nxt  = 1'b1;
        awaddr_nxt  = wrAddr;
        wdata_nxt   = wrData;
      end else if (rd) begin
        araddr_nxt  = rdAddr;
      end
    end

    // The ready/valid levels of the remaining channels follow the state being entered.
    arvalid_nxt = (state_nxt == RD_AR);
    bready_nxt  = (state_nxt == WR_B);
    rready_nxt  = (state_nxt == RD_R);
    busy_nxt    = (state_nxt != IDLE);
    done_nxt    = b_fire | r_fire;

    if (b_fire) begin
      err_nxt = (m_axi.M_AXI_BRESP != 2'b00);
    end
    if (r_fire) begin
      err_nxt     = (m_axi.M_AXI_RRESP != 2'b00);
      rd_data_nxt = m_axi.M_AXI_RDATA;
    end
  end

  assign m_axi.M_AXI_AWADDR  = awaddr_r;
  assign m_axi.M_AXI_AWVALID = awvalid_r;
  assign m_axi.M_AXI_WDATA   = wdata_r;
  assign m_axi.M_AXI_WSTRB   = {SW{1'b1}};
  assign m_axi.M_AXI_WVALID  = wvalid_r;
  assign m_axi.M_AXI_BREADY  = bready_r;
  assign m_axi.M_AXI_ARADDR  = araddr_r;
  assign m_axi.M_AXI_ARVALID = arvalid_r;
  assign m_axi.M_AXI_RREADY  = rready_r;

  assign busy   = busy_r;
  assign done   = done_r;
  assign err    = err_r;
  assign rdData = rd_data_r;

endmodule
